tx_tristate_driver: RTL and testbench

- Multi-channel, parametrised tristate line-driver controller for UART/RS-485-style transmit lines toward the DM electronics.
- Each channel owns its D/E pair, which feeds an external single-bit tristate IO buffer.
- Sequences driver enable with a programmable lead guard before data and a lag guard after data, so lines never float mid-frame and release cleanly for bus turnaround.
- A global force-high-Z input releases all lines at once.

---
 rtl/tx_drv_pkg.sv | 13 +
 rtl/tx_drv_channel.sv | 86 ++++++++
 rtl/tx_tristate_driver.sv | 39 +++
 tb/tb_tx_tristate_driver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/tx_drv_pkg.sv
// rtl/tx_drv_pkg.sv - shared state encoding and counter sizing for the tristate TX driver
package tx_drv_pkg;

   typedef enum logic [1:0] {IDLE, PRE, ACTIVE, POST} tx_drv_state_t;

   // Wide enough to hold the larger guard length; never narrower than one bit.
   function automatic int cnt_width(input int lead, input int lag);
      int hi;
      hi = (lead > lag) ? lead : lag;
      return (hi < 1) ? 1 : $clog2(hi + 1);
   endfunction

endpackage

// File: rtl/tx_drv_channel.sv
// rtl/tx_drv_channel.sv - one TX line: lead/lag guarded driver enable with registered D/E
module tx_drv_channel
   import tx_drv_pkg::*;
#(
   parameter int   LEAD_CYCLES = 8,
   parameter int   LAG_CYCLES  = 16,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tx_req,
   input  logic tx_data,
   input  logic hiz_force,
   output logic tx_d,
   output logic tx_e,
   output logic tx_ready,
   output logic busy
);

   localparam int CW = cnt_width(LEAD_CYCLES, LAG_CYCLES);
   localparam logic [CW-1:0] LEAD_LAST = CW'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
   localparam logic [CW-1:0] LAG_LAST  = CW'((LAG_CYCLES > 0) ? LAG_CYCLES - 1 : 0);

   tx_drv_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (tx_req) begin
               cnt_nxt = '0;
               if (LEAD_CYCLES > 0) state_nxt = PRE;
               else                 state_nxt = ACTIVE;
            end
         end
         PRE: begin
            if (!tx_req) begin
               cnt_nxt = '0;
               if (LAG_CYCLES > 0) state_nxt = POST;
               else                state_nxt = IDLE;
            end else if (cnt == LEAD_LAST) begin
               state_nxt = ACTIVE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ACTIVE: begin
            if (!tx_req) begin
               cnt_nxt = '0;
               if (LAG_CYCLES > 0) state_nxt = POST;
               else                state_nxt = IDLE;
            end
         end
         POST: begin
            // Line is still driven, so a new request skips the lead guard.
            if (tx_req)                 state_nxt = ACTIVE;
            else if (cnt == LAG_LAST)   state_nxt = IDLE;
            else                        cnt_nxt   = cnt_inc;
         end
         default: state_nxt = IDLE;
      endcase
      if (hiz_force) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         tx_e  <= 1'b0;
         tx_d  <= IDLE_LEVEL;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tx_e  <= (state_nxt != IDLE);
         tx_d  <= (state_nxt == ACTIVE) ? tx_data : IDLE_LEVEL;
      end
   end

   assign tx_ready = (state == ACTIVE);
   assign busy     = (state != IDLE);

endmodule

// File: rtl/tx_tristate_driver.sv
// rtl/tx_tristate_driver.sv - multi-channel tristate TX line driver with global high-Z kill
module tx_tristate_driver
   import tx_drv_pkg::*;
#(
   parameter int   CHANNELS    = 4,
   parameter int   LEAD_CYCLES = 8,
   parameter int   LAG_CYCLES  = 16,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] tx_req,
   input  logic [CHANNELS-1:0] tx_data,
   input  logic                hiz_force,
   output logic [CHANNELS-1:0] tx_d,
   output logic [CHANNELS-1:0] tx_e,
   output logic [CHANNELS-1:0] tx_ready,
   output logic [CHANNELS-1:0] busy
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      tx_drv_channel #(
         .LEAD_CYCLES (LEAD_CYCLES),
         .LAG_CYCLES  (LAG_CYCLES),
         .IDLE_LEVEL  (IDLE_LEVEL)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .tx_req    (tx_req[i]),
         .tx_data   (tx_data[i]),
         .hiz_force (hiz_force),
         .tx_d      (tx_d[i]),
         .tx_e      (tx_e[i]),
         .tx_ready  (tx_ready[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_tx_tristate_driver.sv
// tb/tb_tx_tristate_driver.sv - scoreboard bench for default guards and zero-guard configurations
module tb_tx_tristate_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a_req, b_req, tx_data;
   logic       hiz_force;
   logic [3:0] a_d, a_e, a_rdy, a_busy;
   logic [3:0] b_d, b_e, b_rdy, b_busy;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_err  = 0;

   typedef struct {
      int         cyc;
      logic [3:0] a_e, a_d, a_r;
      logic [3:0] b_e, b_d, b_r;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tx_tristate_driver #(.CHANNELS(4), .LEAD_CYCLES(8), .LAG_CYCLES(16), .IDLE_LEVEL(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_req(a_req), .tx_data(tx_data), .hiz_force(hiz_force),
      .tx_d(a_d), .tx_e(a_e), .tx_ready(a_rdy), .busy(a_busy));

   tx_tristate_driver #(.CHANNELS(4), .LEAD_CYCLES(0), .LAG_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .tx_req(b_req), .tx_data(tx_data), .hiz_force(hiz_force),
      .tx_d(b_d), .tx_e(b_e), .tx_ready(b_rdy), .busy(b_busy));

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check("a_tx_e",  a_e,    e.a_e);
         check("a_tx_d",  a_d,    e.a_d);
         check("a_ready", a_rdy,  e.a_r);
         check("a_busy",  a_busy, e.a_e);
         check("b_tx_e",  b_e,    e.b_e);
         check("b_tx_d",  b_d,    e.b_d);
         check("b_ready", b_rdy,  e.b_r);
         check("b_busy",  b_busy, e.b_e);
      end
   end

   // Drive one edge's inputs; act = channels expected in ACTIVE after the edge, en = expected driven.
   task automatic drive(input logic [3:0] ar, input logic [3:0] br, input logic hz,
                        input logic [3:0] aact, input logic [3:0] aen,
                        input logic [3:0] bact, input logic [3:0] ben);
      exp_t e;
      a_req     = ar;
      b_req     = br;
      hiz_force = hz;
      tx_data   = 4'($urandom);
      e.cyc = cyc + 1;
      e.a_e = aen;
      e.a_r = aact;
      e.a_d = (aact & tx_data) | ~aact;
      e.b_e = ben;
      e.b_r = bact;
      e.b_d = (bact & tx_data) | ~bact;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic release_a(input logic [3:0] mask, input int n);
      for (int j = 0; j < n; j++) drive(4'h0, 4'h0, 1'b0, 4'h0, (j < 16) ? mask : 4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      logic [3:0] br;
      rst_n = 1'b0; a_req = 4'h0; b_req = 4'h0; tx_data = 4'h0; hiz_force = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) drive(4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) drive(4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < 30; i++) drive(4'h1, 4'h0, 1'b0, (i >= 8) ? 4'h1 : 4'h0, 4'h1, 4'h0, 4'h0);
      release_a(4'h1, 20);

      for (int i = 0; i < 12; i++) drive(4'h1, 4'h0, 1'b0, (i >= 8) ? 4'h1 : 4'h0, 4'h1, 4'h0, 4'h0);
      for (int j = 0; j < 5; j++)  drive(4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0);
      for (int i = 0; i < 4; i++)  drive(4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
      release_a(4'h1, 17);

      for (int i = 0; i < 3; i++) drive(4'h1, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0);
      release_a(4'h1, 17);

      for (int i = 0; i < 10; i++) drive(4'hF, 4'h0, 1'b0, (i >= 8) ? 4'hF : 4'h0, 4'hF, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++)  drive(4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 10; i++) drive(4'hF, 4'h0, 1'b0, (i >= 8) ? 4'hF : 4'h0, 4'hF, 4'h0, 4'h0);
      drive(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      drive(4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < 10; i++) drive(4'h4, 4'h0, 1'b0, (i >= 8) ? 4'h4 : 4'h0, 4'h4, 4'h0, 4'h0);
      rst_n = 1'b0;
      drive(4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) drive(4'h4, 4'h0, 1'b0, (i >= 8) ? 4'h4 : 4'h0, 4'h4, 4'h0, 4'h0);
      release_a(4'h4, 17);

      for (int s = 0; s < 12; s++) begin
         br = {(s >= 3 && s <= 9), 1'b0, (s <= 5), 1'b0};
         drive(4'h0, br, 1'b0, 4'h0, 4'h0, br, br);
      end
      for (int i = 0; i < 2; i++) drive(4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      @(negedge clk);
      @(negedge clk);
      check("sb_drain", {3'b000, sb.size() != 0}, 4'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
